mips_cpu_mem_bridge: RTL
========================

MIPS_CPU_MEM_BRIDGE -- requirements
Module: mips_cpu_mem_bridge

Interface
REQ-001 Parameter IBUF_EN, default 1, meaning: 1 enables the single-entry instruction buffer; 0 fetches on every step.
REQ-002 Port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1, asynchronous active-low reset (0 = in reset).
REQ-004 Port cpu_active, input, 1, the CPU's active output; 0 means halted.
REQ-005 Port instr_address, input, 32, the CPU fetch address.
REQ-006 Port instr_readdata, output, 32, registered fetched instruction to the CPU.
REQ-007 Port data_address, input, 32, the CPU data address.
REQ-008 Ports data_read and data_write, input, 1 each, the CPU data access strobes.
REQ-009 Port data_writedata, input, 32, the CPU store data.
REQ-010 Port data_readdata, output, 32, registered load data to the CPU.
REQ-011 Port clk_enable, output, 1, the CPU step strobe.
REQ-012 Port bus_address, output, 32, word-aligned memory address.
REQ-013 Ports bus_read and bus_write, output, 1 each, the memory access strobes.
REQ-014 Port bus_writedata, output, 32, memory store data.
REQ-015 Port bus_byteenable, output, 4, byte lanes; always 4'b1111.
REQ-016 Port bus_waitrequest, input, 1, slave stall.
REQ-017 Port bus_readdata, input, 32, memory read data.

Function
REQ-018 The FSM SHALL have states I_CHK, I_BUS, D_CHK, D_BUS and STEP, and SHALL perform at most one bus transaction at a time.
REQ-019 In I_CHK with cpu_active=0, the FSM SHALL stay in I_CHK with no bus strobe and clk_enable=0.
REQ-020 In I_CHK with cpu_active=1, a buffer hit (IBUF_EN=1, ibuf_valid=1, ibuf_addr==instr_address) SHALL go to D_CHK; otherwise the FSM SHALL go to I_BUS.
REQ-021 In I_BUS: bus_read=1 and bus_address={instr_address[31:2],2'b00}. On an edge with bus_waitrequest=0 the block SHALL capture bus_readdata into instr_readdata and the buffer (ibuf_addr and ibuf_valid=1), then go to D_CHK.
REQ-022 In D_CHK the block SHALL latch data_address (bits 1:0 forced to 00) and data_writedata into internal registers.
REQ-023 From D_CHK:
- data_write=1 SHALL go to D_BUS as a write; this holds even when data_read=1 (write wins, read dropped).
- data_read=1 alone SHALL go to D_BUS as a read.
- Neither strobe SHALL go to STEP.
REQ-024 In D_BUS the block SHALL drive the latched address and data with bus_write or bus_read; these SHALL hold stable while bus_waitrequest=1.
REQ-025 On D_BUS completion (waitrequest=0): a read SHALL capture data_readdata, then the FSM SHALL go to STEP.
REQ-026 A completed write whose word address equals ibuf_addr SHALL clear ibuf_valid.
REQ-027 STEP SHALL assert clk_enable=1 for exactly one cycle and return to I_CHK; clk_enable SHALL be 0 in every other state.
REQ-028 Zero-wait latency SHALL be:
- buffer miss, no data access: 4 cycles per step;
- buffer miss with data access: 5 cycles per step;
- buffer hit, no data access: 3 cycles per step.
Each waitrequest cycle SHALL add exactly one cycle.
REQ-029 bus_read and bus_write SHALL never both be 1.
REQ-030 instr_readdata and data_readdata SHALL change only on capture edges.

Reset
REQ-031 While reset=0, all of the following SHALL hold immediately (asynchronously): state=I_CHK, bus_read=0, bus_write=0, clk_enable=0, ibuf_valid=0, instr_readdata=0, data_readdata=0, bus_address=0, bus_writedata=0.
REQ-032 Reset asserted mid-transaction SHALL abort it with no capture. The first transaction after release SHALL start from I_CHK.

Structure
REQ-033 The state enum and BYTEEN_ALL=4'b1111 SHALL live in the shared package mips_cpu_pkg.
REQ-034 The instruction buffer (address tag, valid bit, data, invalidate port) SHALL be one sub-module named mips_cpu_ibuf; the rest of the block SHALL be flat.

Verification
REQ-035 Release reset with cpu_active=1, instr_address=32'hBFC00000, zero-wait slave returning 32'h24020005 -> bus_read at BFC00000 for 1 cycle; instr_readdata=24020005; clk_enable pulses 4 cycles after the fetch start.
REQ-036 Repeat the same instr_address with IBUF_EN=1 -> no bus_read; clk_enable period is 3 cycles.
REQ-037 data_read=1, data_address=32'h00001006, slave returns 32'hDEADBEEF with 2 waitrequest cycles -> bus_address=00001004 stable for 3 cycles; data_readdata=DEADBEEF; clk_enable only after completion.
REQ-038 data_write=1 and data_read=1 together, address equal to the buffered instruction address, writedata 32'h12345678 -> one bus_write only, no bus_read; the next step refetches the instruction over the bus.
REQ-039 Assert reset during I_BUS with waitrequest=1 -> bus_read drops in the same cycle; instr_readdata=0; after release the fetch restarts from I_CHK.
REQ-040 cpu_active=0 for 10 cycles -> no bus strobes and clk_enable=0 throughout.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the MIPS CPU memory bridge: FSM state encoding,
// byte-lane constant and address helpers.
package mips_cpu_pkg;

    typedef enum logic [2:0] {
        I_CHK = 3'd0,
        I_BUS = 3'd1,
        D_CHK = 3'd2,
        D_BUS = 3'd3,
        STEP  = 3'd4
    } state_e;

    localparam logic [3:0] BYTEEN_ALL = 4'b1111;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mips_cpu_ibuf.sv
// Single-entry instruction buffer: address tag, valid bit and the last
// fetched instruction word, with invalidation on a matching store.
module mips_cpu_ibuf
    import mips_cpu_pkg::*;
#(
    parameter int unsigned EN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] lookup_addr,
    output logic        hit,
    input  logic        fill,
    input  logic [31:0] fill_addr,
    input  logic [31:0] fill_data,
    output logic [31:0] data,
    input  logic        inv,
    input  logic [31:2] inv_word
);

    logic [31:0] tag;
    logic        valid;

    // data always tracks the last fetch so it doubles as the CPU-facing
    // instruction register even when the buffer is disabled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag   <= '0;
            valid <= 1'b0;
            data  <= '0;
        end else if (fill) begin
            tag   <= fill_addr;
            valid <= 1'b1;
            data  <= fill_data;
        end else if (inv && (inv_word == tag[31:2])) begin
            valid <= 1'b0;
        end
    end

    assign hit = (EN != 0) && valid && (tag == lookup_addr);

endmodule

// File: rtl/mips_cpu_mem_bridge.sv
// Bridges a single-cycle MIPS CPU to a waitrequest-style memory bus: one
// fetch plus at most one data access per CPU step, then a clk_enable pulse.
module mips_cpu_mem_bridge
    import mips_cpu_pkg::*;
#(
    parameter int unsigned IBUF_EN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_active,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        clk_enable,
    output logic [31:0] bus_address,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] bus_writedata,
    output logic [3:0]  bus_byteenable,
    input  logic        bus_waitrequest,
    input  logic [31:0] bus_readdata
);

    state_e      state;
    state_e      state_next;
    logic [31:2] d_word;
    logic [31:0] d_wdata;
    logic        d_is_write;
    logic        bus_done;
    logic        ibuf_hit;
    logic        ibuf_fill;
    logic        ibuf_inv;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^data_address[1:0];
    assign bus_done  = !bus_waitrequest;
    assign ibuf_fill = (state == I_BUS) && bus_done;
    assign ibuf_inv  = (state == D_BUS) && d_is_write && bus_done;

    mips_cpu_ibuf #(
        .EN(IBUF_EN)
    ) u_ibuf (
        .clk        (clk),
        .reset      (reset),
        .lookup_addr(instr_address),
        .hit        (ibuf_hit),
        .fill       (ibuf_fill),
        .fill_addr  (instr_address),
        .fill_data  (bus_readdata),
        .data       (instr_readdata),
        .inv        (ibuf_inv),
        .inv_word   (d_word)
    );

    always_comb begin
        state_next = state;
        case (state)
            I_CHK:   if (cpu_active) state_next = ibuf_hit ? D_CHK : I_BUS;
            I_BUS:   if (bus_done) state_next = D_CHK;
            D_CHK:   state_next = (data_read || data_write) ? D_BUS : STEP;
            D_BUS:   if (bus_done) state_next = STEP;
            STEP:    state_next = I_CHK;
            default: state_next = I_CHK;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= I_CHK;
        end else begin
            state <= state_next;
        end
    end

    // write takes priority when both strobes are raised together
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_word     <= '0;
            d_wdata    <= '0;
            d_is_write <= 1'b0;
        end else if (state == D_CHK) begin
            d_word     <= data_address[31:2];
            d_wdata    <= data_writedata;
            d_is_write <= data_write;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_readdata <= '0;
        end else if ((state == D_BUS) && !d_is_write && bus_done) begin
            data_readdata <= bus_readdata;
        end
    end

    assign bus_read       = (state == I_BUS) || ((state == D_BUS) && !d_is_write);
    assign bus_write      = (state == D_BUS) && d_is_write;
    assign bus_writedata  = bus_write ? d_wdata : '0;
    assign clk_enable     = (state == STEP);
    assign bus_byteenable = BYTEEN_ALL;

    always_comb begin
        bus_address = '0;
        if (state == I_BUS) begin
            bus_address = word_align(instr_address);
        end else if (state == D_BUS) begin
            bus_address = {d_word, 2'b00};
        end
    end

endmodule
